// File: rtl/axis_frame_stats.sv
// AXI-Stream tap statistics sink: per-frame length/bad/saturation status (1-cycle latency) and wrapping counters.
// Never stalls the stream; a status held by low m_status_ready causes later ones to drop (counted when AXIS_FRAME_STATS_DROP_CNT_EN).
module axis_frame_stats #(
  parameter int                    DATA_WIDTH           = 8,
  parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH           = (DATA_WIDTH / 8),
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
  parameter int                    LEN_WIDTH            = 16,
  parameter int                    COUNT_WIDTH          = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s_axis_tuser,
  output logic [LEN_WIDTH-1:0]   m_status_len,
  output logic                   m_status_bad,
  output logic                   m_status_sat,
  output logic                   m_status_valid,
  input  logic                   m_status_ready,
  input  logic                   stat_clear,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] byte_count,
  output logic [COUNT_WIDTH-1:0] bad_frame_count,
  output logic [COUNT_WIDTH-1:0] status_drop_count
);

  localparam int BB_W  = $clog2(KEEP_WIDTH + 1);
  localparam int SUM_W = ((LEN_WIDTH > BB_W) ? LEN_WIDTH : BB_W) + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   tready_q;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   sat_q, sat_d;
  logic [LEN_WIDTH-1:0]   st_len_q;
  logic                   st_bad_q, st_sat_q;
  logic                   st_vld_q, st_vld_d;
  logic [COUNT_WIDTH-1:0] frame_cnt_q, byte_cnt_q, bad_cnt_q;

  logic [BB_W-1:0]        beat_bytes;
  logic [LEN_WIDTH-1:0]   len_base;
  logic                   sat_base;
  logic [SUM_W-1:0]       len_sum;
  logic                   len_ovf;
  logic                   beat_acc, frame_end, frame_bad;
  logic                   status_busy, status_load, status_drop;
  logic                   unused_keep;

  assign unused_keep = ^s_axis_tkeep;

  always_comb begin
    beat_bytes = '0;
    if (KEEP_ENABLE) begin
      for (int i = 0; i < KEEP_WIDTH; i++) begin
        beat_bytes = beat_bytes + BB_W'(s_axis_tkeep[i]);
      end
    end else begin
      beat_bytes = BB_W'(KEEP_WIDTH);
    end
  end

  assign beat_acc    = s_axis_tvalid & tready_q;
  assign frame_end   = beat_acc & s_axis_tlast;
  assign frame_bad   = ((s_axis_tuser & USER_BAD_FRAME_MASK) ==
                        (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));
  // A finishing frame only loses its status when the previous one is still unclaimed this cycle.
  assign status_busy = st_vld_q & ~m_status_ready;
  assign status_load = frame_end & ~status_busy;
  assign status_drop = frame_end & status_busy;

  always_comb begin
    len_base = (state_q == FRAME) ? len_q : '0;
    sat_base = (state_q == FRAME) & sat_q;
    len_sum  = SUM_W'(len_base) + SUM_W'(beat_bytes);
    len_ovf  = (len_sum > SUM_W'(LEN_MAX));
    state_d  = state_q;
    len_d    = len_q;
    sat_d    = sat_q;
    if (beat_acc) begin
      len_d   = len_ovf ? LEN_MAX : len_sum[LEN_WIDTH-1:0];
      sat_d   = sat_base | len_ovf;
      state_d = s_axis_tlast ? IDLE : FRAME;
    end
  end

  always_comb begin
    st_vld_d = st_vld_q;
    if (status_load) begin
      st_vld_d = 1'b1;
    end else if (m_status_ready) begin
      st_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tready_q <= 1'b0;
      len_q    <= '0;
      sat_q    <= 1'b0;
      st_vld_q <= 1'b0;
      st_len_q <= '0;
      st_bad_q <= 1'b0;
      st_sat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= 1'b1;
      len_q    <= len_d;
      sat_q    <= sat_d;
      st_vld_q <= st_vld_d;
      if (status_load) begin
        st_len_q <= len_d;
        st_bad_q <= frame_bad;
        st_sat_q <= sat_d;
      end
    end
  end

  // Clear has priority, so an increment landing in the clear cycle is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      byte_cnt_q  <= '0;
      bad_cnt_q   <= '0;
    end else if (stat_clear) begin
      frame_cnt_q <= '0;
      byte_cnt_q  <= '0;
      bad_cnt_q   <= '0;
    end else begin
      if (beat_acc) begin
        byte_cnt_q <= byte_cnt_q + COUNT_WIDTH'(beat_bytes);
      end
      if (frame_end) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (frame_end && frame_bad) begin
        bad_cnt_q <= bad_cnt_q + 1'b1;
      end
    end
  end

`ifdef AXIS_FRAME_STATS_DROP_CNT_EN
  logic [COUNT_WIDTH-1:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (stat_clear) begin
      drop_cnt_q <= '0;
    end else if (status_drop) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign status_drop_count = drop_cnt_q;
`else
  logic unused_drop;

  assign unused_drop       = status_drop;
  assign status_drop_count = '0;
`endif

  assign s_axis_tready   = tready_q;
  assign m_status_len    = st_len_q;
  assign m_status_bad    = st_bad_q;
  assign m_status_sat    = st_sat_q;
  assign m_status_valid  = st_vld_q;
  assign frame_count     = frame_cnt_q;
  assign byte_count      = byte_cnt_q;
  assign bad_frame_count = bad_cnt_q;

endmodule

// File: tb/tb_axis_frame_stats.sv
// Directed bench for axis_frame_stats (32-bit stream, 4-bit length) with a status scoreboard.
module tb_axis_frame_stats;

  localparam int LW = 4;
  localparam int CW = 32;
`ifdef AXIS_FRAME_STATS_DROP_CNT_EN
  localparam int EXP_DROP = 1;
`else
  localparam int EXP_DROP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [0:0]    s_axis_tuser = '0;
  logic [LW-1:0] m_status_len;
  logic          m_status_bad, m_status_sat, m_status_valid;
  logic          m_status_ready = 1'b1;
  logic          stat_clear = 1'b0;
  logic [CW-1:0] frame_count, byte_count, bad_frame_count, status_drop_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [LW-1:0] len;
    logic          bad;
    logic          sat;
  } exp_t;
  exp_t exp_q[$];

  axis_frame_stats #(
    .DATA_WIDTH (32),
    .LEN_WIDTH  (LW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .m_status_len     (m_status_len),
    .m_status_bad     (m_status_bad),
    .m_status_sat     (m_status_sat),
    .m_status_valid   (m_status_valid),
    .m_status_ready   (m_status_ready),
    .stat_clear       (stat_clear),
    .frame_count      (frame_count),
    .byte_count       (byte_count),
    .bad_frame_count  (bad_frame_count),
    .status_drop_count(status_drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_status(input logic [LW-1:0] len, input logic bad, input logic sat);
    exp_t e;
    e.len = len;
    e.bad = bad;
    e.sat = sat;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic [3:0] k, input logic l, input logic u, input logic clr);
    s_axis_tvalid = 1'b1;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    stat_clear    = clr;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    stat_clear    = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag, input int fc, input int bc, input int bad);
    chk({tag, "_frame_count"}, frame_count, fc);
    chk({tag, "_byte_count"}, byte_count, bc);
    chk({tag, "_bad_count"}, bad_frame_count, bad);
  endtask

  // Status monitor: a transfer happens at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && m_status_valid && m_status_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_status", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("status_len", m_status_len, e.len);
        chk("status_bad", m_status_bad, e.bad);
        chk("status_sat", m_status_sat, e.sat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_valid", m_status_valid, 0);
    chk_counts("rst", 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    chk("tready_after_rst", s_axis_tready, 1);

    // 3-beat frame: 4+4+2 bytes
    expect_status(4'd10, 1'b0, 1'b0);
    beat(4'hF, 0, 0, 0);
    beat(4'hF, 0, 0, 0);
    beat(4'h3, 1, 0, 0);
    chk("f1_valid_next_cycle", m_status_valid, 1);
    chk_counts("f1", 1, 10, 0);
    idle();
    chk("f1_valid_drops", m_status_valid, 0);

    // single-beat bad frame, then single-beat frame proves state stayed IDLE
    expect_status(4'd4, 1'b1, 1'b0);
    beat(4'hF, 1, 1, 0);
    chk_counts("f2", 2, 14, 1);
    expect_status(4'd1, 1'b0, 1'b0);
    beat(4'h1, 1, 0, 0);
    chk_counts("f3", 3, 15, 1);

    // 20 bytes saturate a 4-bit length; next frame restarts clean
    expect_status(4'd15, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) beat(4'hF, (i == 4), 0, 0);
    chk_counts("f4_sat", 4, 35, 1);
    expect_status(4'd3, 1'b0, 1'b0);
    beat(4'h3, 0, 0, 0);
    beat(4'h1, 1, 0, 0);
    chk_counts("f5", 5, 38, 1);
    idle();

    // held status with ready low: second frame's status is dropped
    m_status_ready = 1'b0;
    expect_status(4'd4, 1'b0, 1'b0);
    beat(4'hF, 1, 0, 0);
    beat(4'h3, 1, 0, 0);
    chk("hold_valid", m_status_valid, 1);
    chk("hold_len", m_status_len, 4);
    chk("drop_count", status_drop_count, EXP_DROP);
    idle();
    chk("hold_len_stable", m_status_len, 4);
    m_status_ready = 1'b1;
    expect_status(4'd1, 1'b0, 1'b0);
    beat(4'h1, 1, 0, 0);
    chk("handshake_load_valid", m_status_valid, 1);
    chk("handshake_load_len", m_status_len, 1);
    chk("drop_count_no_new_drop", status_drop_count, EXP_DROP);
    chk_counts("f8", 8, 45, 1);
    idle();
    chk("after_handshake_valid", m_status_valid, 0);

    // stat_clear on the last beat wins over the increment
    expect_status(4'd8, 1'b0, 1'b0);
    beat(4'hF, 0, 0, 0);
    beat(4'hF, 1, 0, 1);
    chk_counts("clear", 0, 0, 0);
    chk("clear_drop_count", status_drop_count, 0);
    chk("clear_status_valid", m_status_valid, 1);

    // asynchronous reset between edges, mid-frame
    beat(4'hF, 0, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_tready", s_axis_tready, 0);
    chk("arst_valid", m_status_valid, 0);
    chk("arst_len", m_status_len, 0);
    chk("arst_bad", m_status_bad, 0);
    chk("arst_sat", m_status_sat, 0);
    chk_counts("arst", 0, 0, 0);
    chk("arst_drop", status_drop_count, 0);
    #2 rst = 1'b0;
    idle();
    chk("tready_after_arst", s_axis_tready, 1);
    expect_status(4'd6, 1'b0, 1'b0);
    beat(4'hF, 0, 0, 0);
    beat(4'h3, 1, 0, 0);
    chk_counts("post_rst", 1, 6, 0);

    idle();
    idle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
